// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver. Synchronises the raw PS/2 clock and data
//   pins, decodes 11-bit frames (start, 8 data bits LSB first, odd parity,
//   stop), and queues good bytes in a show-ahead FIFO. Framing/parity
//   failures and FIFO drops are reported through sticky flags.
//
//   Optional feature macro: PS2_RX_FILTER_EN
//     When defined, the synchronised ps2_clk passes through a glitch filter.
//     The filter only follows a new level after it has been stable for
//     4 clk cycles, so edges arrive 4 cycles later.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   rd_en       pop strobe, one entry per high cycle (ignored when empty)
//   clr_err     clears overflow and parity_err (a same-cycle set wins)
//   data        FIFO head byte, 8'h00 when empty
//   ready       FIFO non-empty
//   count       FIFO occupancy
//   overflow    sticky: good frame dropped because FIFO was full
//   parity_err  sticky: frame failed start, parity or stop check
//
// FSM
//   state  | meaning
//   IDLE   | waiting for a start bit (0) on a fall pulse
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop + odd parity, pushing the byte if good
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and fall detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_lvl;
    logic                   fall;
    logic                   bit_in;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    end

`ifdef PS2_RX_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] fcnt_q, fcnt_d;

    // The 4th consecutive cycle of disagreement flips the filtered level.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 2'd0;
        if (clk_sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == 2'd3) begin
                filt_d = clk_sync_q[SYNC_STAGES-1];
            end else begin
                fcnt_d = fcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= 2'd0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign clk_lvl = filt_q;
`else
    assign clk_lvl = clk_sync_q[SYNC_STAGES-1];
`endif

    assign clk_prev_d = clk_lvl;
    assign fall       = clk_prev_q & ~clk_lvl;
    assign bit_in     = dat_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      sreg_q, sreg_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            push_req;
    logic            perr_set;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        par_d    = par_q;
        tmo_d    = '0;
        push_req = 1'b0;
        perr_set = 1'b0;

        if (state_q != IDLE && !fall) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    sreg_d   = {bit_in, sreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    if (bit_in && (^{sreg_q, par_q})) begin
                        push_req = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          perr_q, perr_d;
    logic          empty, full, pop, push, drop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(FIFO_DEPTH));
        // A pop needs a stored entry, so push+pop while empty only pushes.
        pop   = rd_en & ~empty;
        push  = push_req & (~full | pop);
        drop  = push_req & full & ~pop;

        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ovf_d  = (ovf_q  & ~clr_err) | drop;
        perr_d = (perr_q & ~clr_err) | perr_set;
    end

    // Storage has no reset; the head is masked to 8'h00 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            sreg_q     <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sreg_q     <= sreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    assign data       = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign ready      = ~empty;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 200;
`ifdef PS2_RX_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       overflow;
    logic       parity_err;

    int total = 0;
    int passed = 0;
    int failed = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH(DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .data(data),
        .ready(ready),
        .count(count),
        .overflow(overflow),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    // Full frame; par_flip inverts the correct odd parity bit. With
    // pop_at_stop, rd_en is high in exactly the cycle of the stop push.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic pop_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ par_flip);
        if (pop_at_stop) begin
            ps2_data = 1'b1;
            cyc(10);
            ps2_clk = 1'b0;
            cyc(SYNC + FL);
            rd_en = 1'b1;
            cyc(1);
            rd_en = 1'b0;
            cyc(19 - SYNC - FL);
            ps2_clk = 1'b1;
            cyc(10);
        end else begin
            send_bit(1'b1);
        end
        cyc(5);
    endtask

    task automatic pop1;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        cyc(3);
        rst = 1'b0;
        cyc(2);
        check("reset_ready", ready, 0);
        check("reset_count", count, 0);
        check("reset_data", data, 8'h00);
        check("reset_ovf", overflow, 0);
        check("reset_perr", parity_err, 0);

        // good frame
        send_frame(8'h1C, 1'b0, 1'b0);
        check("good_ready", ready, 1);
        check("good_data", data, 8'h1C);
        check("good_count", count, 1);
        check("good_perr", parity_err, 0);
        check("good_ovf", overflow, 0);
        pop1();
        check("good_pop_ready", ready, 0);
        check("good_pop_count", count, 0);
        check("good_pop_data", data, 8'h00);
        pop1();
        check("empty_pop_count", count, 0);

        // bad parity
        send_frame(8'h1C, 1'b1, 1'b0);
        check("badpar_count", count, 0);
        check("badpar_perr", parity_err, 1);
        pulse_clr();
        check("badpar_clr", parity_err, 0);

        // overflow with pointers starting at 1 (wraps)
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", data, 8'h01);
        check("ovf_perr", parity_err, 0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_read%0d", i), data, i);
            pop1();
        end
        check("ovf_drain_count", count, 0);
        check("ovf_drain_ready", ready, 0);
        check("ovf_sticky", overflow, 1);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // full FIFO, push and pop in the same cycle
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("full_count", count, 8);
        send_frame(8'hAA, 1'b0, 1'b1);
        check("pushpop_count", count, 8);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_head", data, 8'h02);
        for (int i = 2; i <= 9; i++) begin
            exp_b = (i == 9) ? 8'hAA : 8'(i);
            check($sformatf("pushpop_read%0d", i), data, exp_b);
            pop1();
        end
        check("pushpop_drain", count, 0);

        // timeout recovery
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(TMO + 20);
        check("tmo_count", count, 0);
        check("tmo_perr", parity_err, 0);
        check("tmo_ovf", overflow, 0);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("tmo_next_count", count, 1);
        check("tmo_next_data", data, 8'hF0);
        check("tmo_next_perr", parity_err, 0);

        // reset mid-frame with state present
        send_frame(8'h33, 1'b1, 1'b0);
        check("pre_rst_perr", parity_err, 1);
        check("pre_rst_count", count, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_ready", ready, 0);
        check("rst_count", count, 0);
        check("rst_data", data, 8'h00);
        check("rst_perr", parity_err, 0);
        check("rst_ovf", overflow, 0);
        ps2_data = 1'b1;
        cyc(20);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("rst_next_count", count, 1);
        check("rst_next_data", data, 8'h5A);
        check("rst_next_perr", parity_err, 0);
        pop1();

`ifdef PS2_RX_FILTER_EN
        // 2-cycle low glitch mid-frame must not shift a bit
        exp_b = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(exp_b[i]);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(10);
        for (int i = 3; i < 8; i++) send_bit(exp_b[i]);
        send_bit(~(^exp_b));
        send_bit(1'b1);
        cyc(5);
        check("glitch_count", count, 1);
        check("glitch_data", data, 8'h3C);
        check("glitch_perr", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver and successor to the single-byte keyboard port. It synchronises the PS/2 clock and data pins, decodes 11-bit device-to-host frames, and checks start, parity and stop bits. Valid scan-code bytes are queued in a show-ahead FIFO of configurable depth, and errors are reported through sticky flags. It sits beside the CPU's memory-mapped keyboard register, in place of the single-byte receiver, and runs on the fast divided system clock.

## Interface
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flops in each pin synchroniser; ≥2.
- TIMEOUT_CYCLES, 20000: clk cycles without a PS/2 falling edge before a partial frame is abandoned; ≥16.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- rd_en  in  1  pop strobe; one entry is popped per high cycle.
- clr_err  in  1  clears overflow and parity_err.
- data  out  8  FIFO head byte; valid while ready=1, 8'h00 when empty.
- ready  out  1  FIFO non-empty.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame failed the start, parity or stop check.

## Operation
- Synchroniser: each pin passes through SYNC_STAGES flops. The fall pulse is high for one cycle when the synchronised clock goes from 1 to 0.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on a fall pulse, except the timeout transition.
  - IDLE: if the sampled bit is 0 (start bit), go to DATA with bitcnt=0. If it is 1, stay in IDLE (glitch).
  - DATA: shift the bit into sreg[7] and shift sreg right, so data arrives LSB first. bitcnt increments. After bit 7, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: the frame is good when the stop bit is 1 and ^{sreg, parity}=1 (odd parity). On a good frame, push sreg. On a bad frame, set parity_err and push nothing. Go to IDLE in either case.
- Timeout: a counter runs in every state except IDLE and is cleared on each fall pulse. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and the partial frame is discarded. parity_err is not set.
- FIFO: show-ahead, with rd_ptr and wr_ptr of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - rd_en while empty is ignored.
  - A push while full with no pop in the same cycle drops the byte and sets overflow. Stored contents are unchanged.
  - A push and a pop in the same cycle while full are both accepted; count is unchanged.
  - A push and a pop in the same cycle while empty: the push is accepted and the pop is ignored, so count becomes 1.
- Sticky flags are cleared by clr_err. If a set event and clr_err occur in the same cycle, the set wins.
- Reset values: FSM=IDLE, pointers=0, count=0, ready=0, data=8'h00, overflow=0, parity_err=0, synchronisers filled with 1.
- Reset mid-frame: the partial frame is lost. The next frame is received normally.

## Timing
- Fall pulse appears SYNC_STAGES+1 clk cycles after ps2_clk falls at the pin (+4 with the filter).
- The FIFO write occurs on the clk edge that ends the stop-bit fall-pulse cycle. ready and count update in the next cycle.
- Pop: data and count update on the clk edge that ends the rd_en cycle, so the next head is visible one cycle later.
- The sticky flags assert in the cycle after the causing event.

## Configuration
- PS2_RX_FILTER_EN defined: the synchronised ps2_clk passes through a glitch filter before edge detection. The filtered level changes only after the synchronised value has been stable for 4 consecutive clk cycles, which adds 4 cycles of edge latency. Pulses of 3 cycles or fewer are ignored.
- PS2_RX_FILTER_EN undefined: the synchronised ps2_clk drives the edge detector directly, and every synchronised transition counts.

## Test plan
- Good frame: send 0x1C with parity bit 0 and stop bit 1. Required: ready=1, data=0x1C, count=1, no flags set. Pulse rd_en: ready=0, count=0.
- Bad parity: send 0x1C with parity bit 1. Required: count stays 0 and parity_err=1. Then pulse clr_err: parity_err=0.
- Overflow and wrap: send 9 frames 0x01..0x09 without reading. Required: count=8, overflow=1, data=0x01. Then read all entries: required read order 0x01..0x08, and 0x09 is never seen. Repeat to confirm the pointers wrap correctly.
- Full push plus pop: with the FIFO full, issue rd_en in the same cycle as the stop-bit push of 0xAA. Required: count stays 8, overflow stays 0, and 0xAA is the last entry read out.
- Timeout recovery: send a start bit and 3 data bits, then idle for TIMEOUT_CYCLES. Required: FSM returns to IDLE with no flags set. A following frame 0xF0 is received correctly.
- Reset and filter: assert rst for 1 cycle mid-frame. Required: all outputs take their reset values, and the next frame 0x5A is received. With PS2_RX_FILTER_EN defined, a 2-cycle low glitch on ps2_clk produces no bit shift.
